// File: rtl/clkrst_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : clkrst_gen                                                   |
// | Description : Board clock/reset conditioning. Generates a system reset     |
// |               that asserts asynchronously, releases synchronously and can  |
// |               be stretched. Also generates NUM_DIV independent single-     |
// |               cycle clock-enable strobes with runtime division ratios.     |
// | Config      : define CLKRST_GEN_RST_STRETCH_EN to include the reset hold   |
// |               counter (RST_HOLD_CYCLES extra cycles after release).        |
// |               Without it, rst_sys_n follows the synchroniser output.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module clkrst_gen #(
  parameter int NUM_DIV         = 2,
  parameter int DIV_WIDTH       = 8,
  parameter int RST_SYNC_STAGES = 2,
  parameter int RST_HOLD_CYCLES = 16
) (
  input  logic                         IO_CLK,
  input  logic                         IO_RST_N,
  input  logic [NUM_DIV*DIV_WIDTH-1:0] div_ratio_i,
  output logic [NUM_DIV-1:0]           clk_en_o,
  output logic                         rst_sys_n
);

  // Reject parameter sets the structure below cannot implement.
  if ((NUM_DIV < 1) || (DIV_WIDTH < 1) || (RST_SYNC_STAGES < 2) || (RST_HOLD_CYCLES < 0)) begin : g_param_check
    $error("clkrst_gen: illegal parameter combination");
  end

  logic [RST_SYNC_STAGES-1:0] r_sync;
  logic                       w_sync_out;
  logic                       w_rst_sys_n;

  // Reset-release synchroniser: cleared asynchronously, shifts in ones after release.
  always_ff @(posedge IO_CLK or negedge IO_RST_N) begin
    if (!IO_RST_N) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[RST_SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign w_sync_out = r_sync[RST_SYNC_STAGES-1];

`ifdef CLKRST_GEN_RST_STRETCH_EN
  // A zero hold count still needs a 1-bit counter to keep the compare legal.
  localparam int                  c_hold_w   = (RST_HOLD_CYCLES > 0) ? $clog2(RST_HOLD_CYCLES + 1) : 1;
  localparam logic [c_hold_w-1:0] c_hold_max = c_hold_w'(RST_HOLD_CYCLES);

  logic [c_hold_w-1:0] r_hold_cnt;
  logic                r_rst_sys_n;

  // Hold counter: runs once the synchroniser has released, saturates at the hold count.
  always_ff @(posedge IO_CLK or negedge IO_RST_N) begin
    if (!IO_RST_N) begin
      r_hold_cnt <= '0;
    end else if (w_sync_out && (r_hold_cnt != c_hold_max)) begin
      r_hold_cnt <= r_hold_cnt + c_hold_w'(1);
    end
  end

  // System reset register: released one edge after the hold count is reached.
  // The sync term matters when the hold count is zero and the counter idles at 0.
  always_ff @(posedge IO_CLK or negedge IO_RST_N) begin
    if (!IO_RST_N) begin
      r_rst_sys_n <= 1'b0;
    end else if (w_sync_out && (r_hold_cnt == c_hold_max)) begin
      r_rst_sys_n <= 1'b1;
    end
  end

  assign w_rst_sys_n = r_rst_sys_n;
`else
  assign w_rst_sys_n = w_sync_out;
`endif

  assign rst_sys_n = w_rst_sys_n;

  for (genvar gi = 0; gi < NUM_DIV; gi++) begin : g_div
    logic [DIV_WIDTH-1:0] r_cnt;
    logic [DIV_WIDTH-1:0] r_ratio_q;
    logic                 r_loaded;
    logic [DIV_WIDTH-1:0] w_ratio_in;
    logic [DIV_WIDTH-1:0] w_ratio_sel;
    logic [DIV_WIDTH-1:0] w_last;
    logic                 w_wrap;

    assign w_ratio_in = div_ratio_i[gi*DIV_WIDTH +: DIV_WIDTH];

    // In the first cycle after release nothing has been latched yet, so the
    // live input defines the first period; afterwards only the latched ratio counts.
    assign w_ratio_sel = r_loaded ? r_ratio_q : w_ratio_in;

    // Terminal count is max(ratio,1)-1, so ratios 0 and 1 both strobe every cycle.
    assign w_last = (w_ratio_sel == '0) ? '0 : (w_ratio_sel - DIV_WIDTH'(1));
    assign w_wrap = (r_cnt == w_last);

    // Channel counter and ratio latch; a new ratio is only taken at a period boundary.
    always_ff @(posedge IO_CLK or negedge IO_RST_N) begin
      if (!IO_RST_N) begin
        r_cnt     <= '0;
        r_ratio_q <= '0;
        r_loaded  <= 1'b0;
      end else if (!w_rst_sys_n) begin
        r_cnt     <= '0;
        r_ratio_q <= '0;
        r_loaded  <= 1'b0;
      end else begin
        r_loaded <= 1'b1;
        if (!r_loaded || w_wrap) begin
          r_ratio_q <= w_ratio_in;
        end
        if (w_wrap) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + DIV_WIDTH'(1);
        end
      end
    end

    assign clk_en_o[gi] = w_rst_sys_n && w_wrap;
  end

endmodule
`default_nettype wire

// File: tb/tb_clkrst_gen.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_clkrst_gen                                                |
// | Description : Self-checking bench for clkrst_gen: vector table, hand       |
// |               sequences for ratio change / glitch / second config, and     |
// |               randomized traffic against a strobe-schedule model.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_clkrst_gen;

`ifdef CLKRST_GEN_RST_STRETCH_EN
  localparam int REL1 = 19;   // 2 sync + 16 hold + 1
  localparam int REL2 = 4;    // 3 sync + 0 hold + 1
`else
  localparam int REL1 = 2;
  localparam int REL2 = 3;
`endif

  typedef struct {
    logic [7:0] r0;
    logic [7:0] r1;
    int         f0;
    int         s0;
    int         f1;
    int         s1;
  } vec_t;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic        rst2_n = 1'b0;
  logic [15:0] ratio  = '0;
  logic [15:0] ratio2 = 16'h01FF;   // ch1 = 1, ch0 = 255
  logic [1:0]  en;
  logic [1:0]  en2;
  logic        sys_n;
  logic        sys2_n;

  int n_tests = 0;
  int n_fail  = 0;
  int m_edges = 0;
  int m_next[2];

  always #5 clk = ~clk;

  clkrst_gen dut (
    .IO_CLK      (clk),
    .IO_RST_N    (rst_n),
    .div_ratio_i (ratio),
    .clk_en_o    (en),
    .rst_sys_n   (sys_n)
  );

  clkrst_gen #(
    .NUM_DIV         (2),
    .DIV_WIDTH       (8),
    .RST_SYNC_STAGES (3),
    .RST_HOLD_CYCLES (0)
  ) dut2 (
    .IO_CLK      (clk),
    .IO_RST_N    (rst2_n),
    .div_ratio_i (ratio2),
    .clk_en_o    (en2),
    .rst_sys_n   (sys2_n)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int eff(input logic [7:0] r);
    return (r == 8'd0) ? 1 : int'(r);
  endfunction

  // Model: rising edges seen since the raw reset was last released.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_edges <= 0;
    else        m_edges <= m_edges + 1;
  end

  // Model: rst_sys_n is high once REL1 edges have passed; each channel strobes
  // on a schedule where every period length is the ratio present in the cycle
  // that starts it (cycle 0, or the strobe cycle ending the previous period).
  always @(negedge clk) begin : model_chk
    logic exp_rst;
    int   c;
    logic exp_en;
    exp_rst = rst_n && (m_edges >= REL1);
    check("model rst_sys_n", sys_n, exp_rst);
    for (int i = 0; i < 2; i++) begin
      exp_en = 1'b0;
      if (exp_rst) begin
        c = m_edges - REL1;
        if (c == 0) m_next[i] = eff(ratio[i*8 +: 8]) - 1;
        if (c == m_next[i]) begin
          exp_en    = 1'b1;
          m_next[i] = m_next[i] + eff(ratio[i*8 +: 8]);
        end
      end
      check($sformatf("model clk_en[%0d]", i), en[i], exp_en);
    end
  end

  // Pulse reset for two cycles with new ratios, then count edges to release.
  task automatic reset_and_release(input logic [15:0] r, output int k);
    @(posedge clk); #1;
    rst_n = 1'b0;
    ratio = r;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    k = 0;
    while (k < 100) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      if (sys_n) break;
    end
  endtask

  vec_t vecs[5];
  int   k;
  int   f0, s0, f1, s1;
  int   q[$];

  initial begin
    vecs[0] = '{8'd4,   8'd1, 3,   7,   0, 1};
    vecs[1] = '{8'd0,   8'd4, 0,   1,   3, 7};
    vecs[2] = '{8'd1,   8'd0, 0,   1,   0, 1};
    vecs[3] = '{8'd2,   8'd3, 1,   3,   2, 5};
    vecs[4] = '{8'd255, 8'd5, 254, 509, 4, 9};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset rst_sys_n", sys_n, 1'b0);
    check("reset clk_en", en, 2'b00);
    check("reset dut2 rst_sys_n", sys2_n, 1'b0);
    check("reset dut2 clk_en", en2, 2'b00);

    // Table-driven vectors: release latency and first two strobes per channel
    for (int t = 0; t < 5; t++) begin
      reset_and_release({vecs[t].r1, vecs[t].r0}, k);
      check($sformatf("vec%0d release edge", t), k, REL1);
      f0 = -1; s0 = -1; f1 = -1; s1 = -1;
      for (int c = 0; c < 600; c++) begin
        if (c > 0) begin
          @(posedge clk);
          @(negedge clk);
        end
        if (en[0]) begin if (f0 < 0) f0 = c; else if (s0 < 0) s0 = c; end
        if (en[1]) begin if (f1 < 0) f1 = c; else if (s1 < 0) s1 = c; end
        if ((s0 >= 0) && (s1 >= 0)) break;
      end
      check($sformatf("vec%0d ch0 first", t),  f0, vecs[t].f0);
      check($sformatf("vec%0d ch0 second", t), s0, vecs[t].s0);
      check($sformatf("vec%0d ch1 first", t),  f1, vecs[t].f1);
      check($sformatf("vec%0d ch1 second", t), s1, vecs[t].s1);
    end

    // Ratio change 4 -> 3 during cycle 5: strobes 3, 7, 10, 13
    reset_and_release({8'd1, 8'd4}, k);
    check("chg release edge", k, REL1);
    q = {};
    for (int c = 0; c < 15; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        if (c == 5) ratio[7:0] = 8'd3;
        @(negedge clk);
      end
      if (en[0]) q.push_back(c);
    end
    check("chg strobe count", q.size(), 4);
    if (q.size() == 4) begin
      check("chg strobe 0", q[0], 3);
      check("chg strobe 1", q[1], 7);
      check("chg strobe 2", q[2], 10);
      check("chg strobe 3", q[3], 13);
    end

    // 0.5 ns-wide...1 ns glitch mid-operation: immediate drop, full restart
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("pre-glitch rst_sys_n", sys_n, 1'b1);
    check("pre-glitch ch1 enable", en[1], 1'b1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #0.5;
    check("glitch rst_sys_n", sys_n, 1'b0);
    check("glitch clk_en", en, 2'b00);
    #0.5 rst_n = 1'b1;
    k = 0;
    while (k < 100) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      if (sys_n) break;
    end
    check("glitch release edge", k, REL1);
    f0 = -1;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) begin
        @(posedge clk);
        @(negedge clk);
      end
      if (en[0] && (f0 < 0)) f0 = c;
    end
    check("glitch ch0 first strobe (ratio 3)", f0, 2);

    // Second configuration: 3 sync stages, no hold, ch0 ratio 255
    @(posedge clk); #1 rst2_n = 1'b1;
    k = 0;
    while (k < 100) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      if (sys2_n) break;
    end
    check("dut2 release edge", k, REL2);
    check("dut2 ch1 cycle0", en2[1], 1'b1);
    f0 = -1; s0 = -1;
    for (int c = 0; c < 520; c++) begin
      if (c > 0) begin
        @(posedge clk);
        @(negedge clk);
      end
      if (en2[0]) begin if (f0 < 0) f0 = c; else if (s0 < 0) s0 = c; end
      if (s0 >= 0) break;
    end
    check("dut2 ch0 first", f0, 254);
    check("dut2 ch0 second", s0, 509);

    // Randomized traffic: ratio changes and resets, checked by the model
    for (int c = 0; c < 4000; c++) begin
      int ch;
      @(posedge clk); #1;
      if ($urandom_range(0, 14) == 0) begin
        ch = $urandom_range(0, 1);
        if ($urandom_range(0, 9) == 0) ratio[ch*8 +: 8] = 8'($urandom_range(0, 40));
        else                           ratio[ch*8 +: 8] = 8'($urandom_range(0, 9));
      end
      if ($urandom_range(0, 399) == 0) begin
        #1 rst_n = 1'b0;
        #0.5 rst_n = 1'b1;
      end else if ($urandom_range(0, 799) == 0) begin
        rst_n = 1'b0;
        #20 rst_n = 1'b1;
      end
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
